// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed 4-digit seven-segment scan driver
//
// Scans four hex digits onto a common-anode style display, one digit per
// slot of REFRESH_DIV cycles, with GUARD dark cycles at the start of each
// slot to suppress ghosting. All pins are registered and active-low.
//
// Optional build macro: SEG7_LZ_BLANK_EN enables leading-zero suppression.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   en         display enable; 0 blanks all anodes, scanning continues
//   digits     four hex nibbles, digits[4k+3:4k] is digit k (0 = rightmost)
//   blank      per-digit forced blank
//   dp_in      per-digit decimal point request
//   an         anode selects, active-low, an[k] drives digit k
//   seg        segments {g,f,e,d,c,b,a}, active-low
//   dp         decimal point, active-low
//   slot_tick  one-cycle pulse after the slot counter wraps
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] digits,
  input  logic [3:0]  blank,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        slot_tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    sel;
  logic          cnt_wrap;
  logic          in_guard;
  logic [3:0]    keep;
  logic [3:0]    nib;
  logic          visible;
  logic [6:0]    font;

  assign cnt_wrap = (cnt == CNT_MAX);

  // With no guard interval the comparison would be constant, so it is
  // elaborated away entirely.
  generate
    if (GUARD == 0) begin : g_no_guard
      assign in_guard = 1'b0;
    end else begin : g_guard
      assign in_guard = (cnt < CW'(GUARD));
    end
  endgenerate

`ifdef SEG7_LZ_BLANK_EN
  // A digit survives if it or any digit above it is non-zero or has its
  // decimal point requested; digit 0 always survives.
  always_comb begin
    keep    = 4'b0001;
    keep[3] = (digits[15:12] != 4'h0) || dp_in[3];
    keep[2] = keep[3] || (digits[11:8] != 4'h0) || dp_in[2];
    keep[1] = keep[2] || (digits[7:4] != 4'h0) || dp_in[1];
  end
`else
  assign keep = 4'b1111;
`endif

  assign nib     = digits[{sel, 2'b00} +: 4];
  assign visible = en && !blank[sel] && !in_guard && keep[sel];

  // Hex font, active-high, bit order {g,f,e,d,c,b,a}.
  always_comb begin
    font = 7'h00;
    case (nib)
      4'h0: font = 7'h3F;
      4'h1: font = 7'h06;
      4'h2: font = 7'h5B;
      4'h3: font = 7'h4F;
      4'h4: font = 7'h66;
      4'h5: font = 7'h6D;
      4'h6: font = 7'h7D;
      4'h7: font = 7'h07;
      4'h8: font = 7'h7F;
      4'h9: font = 7'h6F;
      4'hA: font = 7'h77;
      4'hB: font = 7'h7C;
      4'hC: font = 7'h39;
      4'hD: font = 7'h5E;
      4'hE: font = 7'h79;
      4'hF: font = 7'h71;
      default: font = 7'h00;
    endcase
  end

  // Slot counter and digit select run regardless of en so that
  // re-enabling resumes mid-scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      sel       <= 2'd0;
      slot_tick <= 1'b0;
    end else begin
      slot_tick <= cnt_wrap;
      if (cnt_wrap) begin
        cnt <= '0;
        sel <= sel + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Pins are computed from the pre-edge sel/cnt, so a slot change and its
  // guard interval appear together and only one anode is ever low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else if (visible) begin
      an  <= ~(4'b0001 << sel);
      seg <= ~font;
      dp  <= ~dp_in[sel];
    end else begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [15:0] digits = 16'h0000;
  logic [3:0]  blank = 4'h0;
  logic [3:0]  dp_in = 4'h0;

  logic [3:0] an0, an1;
  logic [6:0] seg0, seg1;
  logic       dp0, dp1, tick0, tick1;

  int checks = 0;
  int errors = 0;
  int k = 0;

  logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_scan_driver #(.REFRESH_DIV(4), .GUARD(1)) u0 (
    .clk(clk), .rst(rst), .en(en), .digits(digits), .blank(blank), .dp_in(dp_in),
    .an(an0), .seg(seg0), .dp(dp0), .slot_tick(tick0)
  );

  seg7_scan_driver #(.REFRESH_DIV(3), .GUARD(0)) u1 (
    .clk(clk), .rst(rst), .en(en), .digits(digits), .blank(blank), .dp_in(dp_in),
    .an(an1), .seg(seg1), .dp(dp1), .slot_tick(tick1)
  );

  always #5 clk = ~clk;

  // Expected pins after edge number n since reset release:
  // {slot_tick, dp, seg, an}.
  function automatic logic [12:0] model(int div, int guard, int n);
    int pos = n % div;
    int s = (n / div) % 4;
    int hi = 0;
    bit vis;
    logic [3:0] a = 4'b1111;
    logic [6:0] sg = 7'h7F;
    logic d = 1'b1;
    vis = en && !blank[s] && (pos >= guard);
`ifdef SEG7_LZ_BLANK_EN
    for (int i = 0; i < 4; i++)
      if (digits[4*i +: 4] != 4'h0 || dp_in[i]) hi = i;
    if (s > hi) vis = 0;
`endif
    if (vis) begin
      a[s] = 1'b0;
      sg = ~font[digits[4*s +: 4]];
      d = ~dp_in[s];
    end
    return {pos == div - 1, d, sg, a};
  endfunction

  task automatic check(string tag, logic [12:0] obs, logic [12:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    check("u0_pins", {tick0, dp0, seg0, an0}, model(4, 1, k));
    check("u1_pins", {tick1, dp1, seg1, an1}, model(3, 0, k));
    k++;
  endtask

  // Assert reset mid-cycle, check the immediate effect, release mid-cycle.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    check("u0_reset", {tick0, dp0, seg0, an0}, {1'b0, 1'b1, 7'h7F, 4'hF});
    check("u1_reset", {tick1, dp1, seg1, an1}, {1'b0, 1'b1, 7'h7F, 4'hF});
    @(posedge clk);
    #3;
    rst = 1'b0;
    k = 0;
  endtask

  always @(negedge clk) begin
    checks++;
    assert ($countones(~an0) <= 1 && $countones(~an1) <= 1) else begin
      errors++;
      $error("FAIL one_hot_an observed=%b/%b required=at most one low", an0, an1);
    end
  end

  initial begin
    do_reset();

    // Basic scan of 12AF.
    en = 1'b1; digits = 16'h12AF; blank = 4'h0; dp_in = 4'h0;
    step();
    step();
    check("first_digit", {2'b00, seg0, an0}, {2'b00, 7'b0001110, 4'b1110});
    repeat (18) step();

    // Reset in the middle of slot 2.
    while (((k / 4) % 4) != 2 || (k % 4) != 2) step();
    do_reset();
    step();
    check("post_rst_guard", {2'b00, seg0, an0}, {2'b00, 7'h7F, 4'b1111});
    step();
    check("post_rst_digit0", {2'b00, seg0, an0}, {2'b00, 7'b0001110, 4'b1110});
    repeat (4) step();

    // Enable toggled off for six cycles.
    repeat (3) step();
    en = 1'b0;
    repeat (6) step();
    en = 1'b1;
    repeat (8) step();

    // Forced blank and decimal points.
    blank = 4'b0101; dp_in = 4'b0010; digits = 16'h8888;
    repeat (20) step();

    // Leading-zero patterns.
    blank = 4'h0; dp_in = 4'h0; digits = 16'h0070;
    repeat (17) step();
    digits = 16'h0000;
    repeat (17) step();
    dp_in = 4'b0100;
    repeat (17) step();

    // Randomized inputs with occasional resets.
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < 4; i++)
          digits[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      end
      if ($urandom_range(0, 7) == 0) blank = 4'($urandom);
      if ($urandom_range(0, 7) == 0) dp_in = 4'($urandom);
      if ($urandom_range(0, 9) == 0) en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 59) == 0) do_reset();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
